// File: rtl/sync_fifo_flags_if.sv
// Handshake bundle for sync_fifo_flags: write side, read side, flags and error status.
interface sync_fifo_flags_if #(
   parameter int unsigned DEPTH_LG2  = 4,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  wren_i;
   logic [DATA_WIDTH-1:0] wdata_i;
   logic                  full_o;
   logic                  afull_o;
   logic                  rden_i;
   logic [DATA_WIDTH-1:0] rdata_o;
   logic                  empty_o;
   logic                  aempty_o;
   logic [DEPTH_LG2:0]    count_o;
   logic                  clr_err_i;
   logic                  overflow_o;
   logic                  underflow_o;

   modport master (
      output wren_i, wdata_i, rden_i, clr_err_i,
      input  full_o, afull_o, rdata_o, empty_o, aempty_o, count_o, overflow_o, underflow_o
   );

   modport slave (
      input  wren_i, wdata_i, rden_i, clr_err_i,
      output full_o, afull_o, rdata_o, empty_o, aempty_o, count_o, overflow_o, underflow_o
   );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// registered or first-word-fall-through read, and sticky overflow/underflow flags.
module sync_fifo_flags #(
   parameter int unsigned DEPTH_LG2  = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned AFULL_TH   = (1 << DEPTH_LG2) - 2,
   parameter int unsigned AEMPTY_TH  = 2,
   parameter bit          FWFT       = 1'b0,
   parameter bit          RST_MEM    = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   sync_fifo_flags_if.slave bus
);
   localparam int unsigned FIFO_DEPTH = 1 << DEPTH_LG2;
   localparam int unsigned PTR_W      = DEPTH_LG2 + 1;
   localparam logic [PTR_W-1:0] DEPTH_C  = PTR_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] AFULL_C  = PTR_W'(AFULL_TH);
   localparam logic [PTR_W-1:0] AEMPTY_C = PTR_W'(AEMPTY_TH);

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]      wrptr_q, wrptr_d;
   logic [PTR_W-1:0]      rdptr_q, rdptr_d;
   logic [PTR_W-1:0]      count_q, count_d;
   logic                  full_q, full_d;
   logic                  afull_q, afull_d;
   logic                  empty_q, empty_d;
   logic                  aempty_q, aempty_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;
   logic                  wr_ok;
   logic                  rd_ok;

   // Next-state: accepted ops move pointers and count; flags decode from the new count.
   always_comb begin
      wr_ok   = bus.wren_i & ~full_q;
      rd_ok   = bus.rden_i & ~empty_q;
      wrptr_d = wrptr_q;
      rdptr_d = rdptr_q;
      count_d = count_q;
      if (wr_ok) wrptr_d = wrptr_q + PTR_W'(1);
      if (rd_ok) rdptr_d = rdptr_q + PTR_W'(1);
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + PTR_W'(1);
         2'b01:   count_d = count_q - PTR_W'(1);
         default: count_d = count_q;
      endcase
      full_d   = (count_d == DEPTH_C);
      afull_d  = (count_d >= AFULL_C);
      empty_d  = (count_d == '0);
      aempty_d = (count_d <= AEMPTY_C);
      // A new error in the same cycle as a clear keeps the flag set.
      ovf_d    = (bus.wren_i & full_q)  | (ovf_q & ~bus.clr_err_i);
      udf_d    = (bus.rden_i & empty_q) | (udf_q & ~bus.clr_err_i);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wrptr_q  <= '0;
         rdptr_q  <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         afull_q  <= 1'b0;
         empty_q  <= 1'b1;
         aempty_q <= 1'b1;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wrptr_q  <= wrptr_d;
         rdptr_q  <= rdptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         afull_q  <= afull_d;
         empty_q  <= empty_d;
         aempty_q <= aempty_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && RST_MEM) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else if (wr_ok && !rst) begin
         mem_q[wrptr_q[DEPTH_LG2-1:0]] <= bus.wdata_i;
      end
   end

   // Read port: head shown directly in FWFT mode, otherwise a load-on-pop register.
   if (FWFT) begin : g_fwft
      assign bus.rdata_o = mem_q[rdptr_q[DEPTH_LG2-1:0]];
   end else begin : g_regrd
      logic [DATA_WIDTH-1:0] rdata_q;
      always_ff @(posedge clk) begin
         if (rst)        rdata_q <= '0;
         else if (rd_ok) rdata_q <= mem_q[rdptr_q[DEPTH_LG2-1:0]];
      end
      assign bus.rdata_o = rdata_q;
   end

   assign bus.count_o     = count_q;
   assign bus.full_o      = full_q;
   assign bus.afull_o     = afull_q;
   assign bus.empty_o     = empty_q;
   assign bus.aempty_o    = aempty_q;
   assign bus.overflow_o  = ovf_q;
   assign bus.underflow_o = udf_q;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: registered-read and FWFT instances share stimulus and a queue model.
module tb_sync_fifo_flags;
   localparam int unsigned LG2  = 2;
   localparam int unsigned DW   = 8;
   localparam int          DEP  = 4;
   localparam int          AFTH = 3;
   localparam int          AETH = 1;

   typedef struct {
      int cnt;
      bit full, afull, empty, aempty, ovf, udf;
      int rd0;
      bit head_v;
      int head;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sync_fifo_flags_if #(.DEPTH_LG2(LG2), .DATA_WIDTH(DW)) bus0 ();
   sync_fifo_flags_if #(.DEPTH_LG2(LG2), .DATA_WIDTH(DW)) bus1 ();

   sync_fifo_flags #(.DEPTH_LG2(LG2), .DATA_WIDTH(DW), .AFULL_TH(AFTH), .AEMPTY_TH(AETH),
                     .FWFT(1'b0), .RST_MEM(1'b0))
      dut0 (.clk(clk), .rst(rst), .bus(bus0));
   sync_fifo_flags #(.DEPTH_LG2(LG2), .DATA_WIDTH(DW), .AFULL_TH(AFTH), .AEMPTY_TH(AETH),
                     .FWFT(1'b1), .RST_MEM(1'b1))
      dut1 (.clk(clk), .rst(rst), .bus(bus1));

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];
   int   mq[$];
   bit   ovf_m = 0, udf_m = 0;
   int   rd0_m = 0;

   task automatic chk(input string name, input int act, input int expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   // One clock of stimulus; the model's post-edge state is queued for the monitor.
   task automatic step(input bit r, input bit w, input int d, input bit rd, input bit clr);
      exp_t e;
      int   n;
      bit   wok, rok, new_ovf, new_udf;
      @(posedge clk);
      #2;
      rst = r;
      bus0.wren_i = w;  bus0.wdata_i = DW'(d); bus0.rden_i = rd; bus0.clr_err_i = clr;
      bus1.wren_i = w;  bus1.wdata_i = DW'(d); bus1.rden_i = rd; bus1.clr_err_i = clr;
      if (r) begin
         mq.delete();
         ovf_m = 0; udf_m = 0; rd0_m = 0;
      end else begin
         n       = mq.size();
         wok     = w && (n < DEP);
         rok     = rd && (n > 0);
         new_ovf = w && !wok;
         new_udf = rd && !rok;
         if (rok) rd0_m = mq.pop_front();
         if (wok) mq.push_back(d);
         ovf_m = new_ovf || (ovf_m && !clr);
         udf_m = new_udf || (udf_m && !clr);
      end
      e.cnt    = mq.size();
      e.full   = (e.cnt == DEP);
      e.afull  = (e.cnt >= AFTH);
      e.empty  = (e.cnt == 0);
      e.aempty = (e.cnt <= AETH);
      e.ovf    = ovf_m;
      e.udf    = udf_m;
      e.rd0    = rd0_m;
      e.head_v = (e.cnt > 0);
      e.head   = e.head_v ? mq[0] : 0;
      exp_q.push_back(e);
   endtask

   // Monitor: after each edge, compare both instances against the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("count0",  int'(bus0.count_o),     e.cnt);
            chk("full0",   int'(bus0.full_o),      int'(e.full));
            chk("afull0",  int'(bus0.afull_o),     int'(e.afull));
            chk("empty0",  int'(bus0.empty_o),     int'(e.empty));
            chk("aempty0", int'(bus0.aempty_o),    int'(e.aempty));
            chk("ovf0",    int'(bus0.overflow_o),  int'(e.ovf));
            chk("udf0",    int'(bus0.underflow_o), int'(e.udf));
            chk("rdata0",  int'(bus0.rdata_o),     e.rd0);
            chk("count1",  int'(bus1.count_o),     e.cnt);
            chk("full1",   int'(bus1.full_o),      int'(e.full));
            chk("afull1",  int'(bus1.afull_o),     int'(e.afull));
            chk("empty1",  int'(bus1.empty_o),     int'(e.empty));
            chk("aempty1", int'(bus1.aempty_o),    int'(e.aempty));
            chk("ovf1",    int'(bus1.overflow_o),  int'(e.ovf));
            chk("udf1",    int'(bus1.underflow_o), int'(e.udf));
            if (e.head_v) chk("head1", int'(bus1.rdata_o), e.head);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int budget;
      rst = 1'b1;
      bus0.wren_i = 0; bus0.wdata_i = '0; bus0.rden_i = 0; bus0.clr_err_i = 0;
      bus1.wren_i = 0; bus1.wdata_i = '0; bus1.rden_i = 0; bus1.clr_err_i = 0;

      step(1, 0, 0, 0, 0);
      step(1, 1, 8'h55, 1, 0);                       // reset wins over requests
      for (int i = 0; i < 4; i++) step(0, 1, 8'hA0 + i, 0, 0);
      step(0, 1, 8'hFF, 0, 0);                       // rejected write when full
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) step(0, 1, 8'hB0 + i, 0, 0);
      step(0, 1, 8'hFF, 1, 0);                       // full: read accepted, write rejected
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);                           // underflow, rdata holds
      step(0, 0, 0, 0, 1);
      step(0, 1, 8'h11, 1, 0);                       // empty: write accepted, read rejected
      step(0, 0, 0, 0, 1);
      step(0, 1, 8'h22, 1, 0);                       // pop 0x11 while writing 0x22
      for (int i = 0; i < 20; i++) step(0, 1, 8'h30 + i, 1, 0);
      step(0, 1, 8'h77, 0, 1);
      step(0, 1, 8'h78, 0, 0);
      step(1, 1, 8'h79, 0, 0);                       // mid-operation reset
      step(0, 0, 0, 1, 0);

      for (int i = 0; i < 600; i++) begin
         int  ph;
         bit  w, rd;
         ph = (i / 50) % 3;
         w  = (ph == 1) ? ($urandom_range(0, 3) != 0) : (ph == 2) ? ($urandom_range(0, 3) == 0)
                        : bit'($urandom_range(0, 1));
         rd = (ph == 2) ? ($urandom_range(0, 3) != 0) : (ph == 1) ? ($urandom_range(0, 3) == 0)
                        : bit'($urandom_range(0, 1));
         step(($urandom_range(0, 99) == 0), w, int'($urandom_range(0, 255)), rd,
              ($urandom_range(0, 7) == 0));
      end
      step(0, 0, 0, 0, 0);

      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      #3;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
